// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings, opcode constants and state enum for mc_ctrl_fsm
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd7;

    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_A  = 2'd1;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] IORD_PC     = 2'd0;
    localparam logic [1:0] IORD_ALUOUT = 2'd1;
    localparam logic [1:0] IORD_EXC    = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_MEM    = 2'd3;

    localparam logic REGDST_RT = 1'b0;
    localparam logic REGDST_RD = 1'b1;

    localparam logic M2R_ALUOUT = 1'b0;
    localparam logic M2R_MEM    = 1'b1;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_OVF  = 2'd1;
    localparam logic [1:0] EXC_OPC  = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_FETCH_WB, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_ALU_WB,
        ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP,
        ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC
    } state_t;

    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_mem_wait_timer.sv
// rtl/mc_ctrl_fsm_mem_wait_timer.sv - clear/enable/done counter timing memory access states
module mem_wait_timer #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign done = (count == 4'(MEM_WAIT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control FSM with exceptions; option MC_CTRL_MEM_READY_EN
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int ADDR_W   = 32,
    parameter int OVF_VEC  = 255,
    parameter int OPC_VEC  = 253
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        OPCODE,
    input  logic [5:0]        FUNCT,
    input  logic              overflow,
    input  logic              zero,
`ifdef MC_CTRL_MEM_READY_EN
    input  logic              MEM_ready,
`endif
    output logic              MEM_read,
    output logic              MEM_write,
    output logic              PC_write,
    output logic              IR_write,
    output logic              REG_write,
    output logic              AB_write,
    output logic              ALUOUT_write,
    output logic              EPC_write,
    output logic [2:0]        ALU_control,
    output logic [1:0]        ALUSRCA_select,
    output logic [1:0]        ALUSRCB_select,
    output logic [1:0]        IORD_select,
    output logic [1:0]        PCSOURCE_select,
    output logic              REGDST_select,
    output logic              MEMTOREG_select,
    output logic [1:0]        EXC_CAUSE,
    output logic [ADDR_W-1:0] EXC_ADDR
);

    state_t state;
    logic   mem_done;
    logic   is_r;
    logic   r_valid;
    logic   ovf_trap;

    // IR stays stable for the whole instruction, so later states re-decode it directly
    assign is_r     = (OPCODE == OP_RTYPE);
    assign r_valid  = is_r && (FUNCT inside {FN_ADD, FN_SUB, FN_AND, FN_SLT});
    assign ovf_trap = overflow && ((is_r && (FUNCT == FN_ADD || FUNCT == FN_SUB)) || OPCODE == OP_ADDI);

`ifdef MC_CTRL_MEM_READY_EN
    assign mem_done = MEM_ready;
`else
    logic in_mem;
    assign in_mem = state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR, ST_EXC_RD};

    // Clearing on exit (and outside memory states) leaves the count at 0 on every entry
    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_mem || mem_done),
        .enable (in_mem),
        .done   (mem_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            EXC_CAUSE <= EXC_NONE;
        end else begin
            case (state)
                ST_IDLE:     state <= ST_FETCH;
                ST_FETCH:    if (mem_done) state <= ST_FETCH_WB;
                ST_FETCH_WB: state <= ST_DECODE;
                ST_DECODE: begin
                    if (r_valid)                                 state <= ST_EXEC_R;
                    else if (OPCODE == OP_ADDI || OPCODE == OP_ADDIU) state <= ST_EXEC_I;
                    else if (OPCODE == OP_LW || OPCODE == OP_SW)  state <= ST_MEM_ADDR;
                    else if (OPCODE == OP_BEQ || OPCODE == OP_BNE) state <= ST_BRANCH;
                    else if (OPCODE == OP_J)                      state <= ST_JUMP;
                    else begin
                        state     <= ST_EXC_EPC;
                        EXC_CAUSE <= EXC_OPC;
                    end
                end
                ST_EXEC_R, ST_EXEC_I: state <= ST_ALU_WB;
                ST_ALU_WB: begin
                    if (ovf_trap) begin
                        state     <= ST_EXC_EPC;
                        EXC_CAUSE <= EXC_OVF;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM_ADDR: state <= (OPCODE == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   if (mem_done) state <= ST_MEM_WB;
                ST_MEM_WR:   if (mem_done) state <= ST_FETCH;
                ST_EXC_EPC:  state <= ST_EXC_RD;
                ST_EXC_RD:   if (mem_done) state <= ST_EXC_PC;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        MEM_read = 1'b0; MEM_write = 1'b0; PC_write = 1'b0; IR_write = 1'b0;
        REG_write = 1'b0; AB_write = 1'b0; ALUOUT_write = 1'b0; EPC_write = 1'b0;
        ALU_control = ALU_PASS; ALUSRCA_select = SRCA_PC; ALUSRCB_select = SRCB_B;
        IORD_select = IORD_PC; PCSOURCE_select = PCSRC_ALU;
        REGDST_select = REGDST_RT; MEMTOREG_select = M2R_ALUOUT;
        case (state)
            ST_FETCH, ST_FETCH_WB: begin
                MEM_read       = 1'b1;
                ALUSRCB_select = SRCB_FOUR;
                ALU_control    = ALU_ADD;
                IR_write       = (state == ST_FETCH_WB);
                PC_write       = (state == ST_FETCH_WB);
            end
            ST_DECODE: begin
                AB_write = 1'b1; ALUOUT_write = 1'b1;
                ALUSRCB_select = SRCB_IMM_SH; ALU_control = ALU_ADD;
            end
            ST_EXEC_R, ST_EXEC_I, ST_ALU_WB: begin
                ALUSRCA_select = SRCA_A;
                ALUSRCB_select = is_r ? SRCB_B : SRCB_IMM;
                ALU_control    = is_r ? funct_alu(FUNCT) : ALU_ADD;
                ALUOUT_write   = (state != ST_ALU_WB);
                REG_write      = (state == ST_ALU_WB) && !ovf_trap;
                REGDST_select  = is_r ? REGDST_RD : REGDST_RT;
            end
            ST_MEM_ADDR: begin
                ALUSRCA_select = SRCA_A; ALUSRCB_select = SRCB_IMM;
                ALU_control = ALU_ADD; ALUOUT_write = 1'b1;
            end
            ST_MEM_RD, ST_MEM_WB: begin
                MEM_read = 1'b1; IORD_select = IORD_ALUOUT;
                REG_write       = (state == ST_MEM_WB);
                MEMTOREG_select = (state == ST_MEM_WB) ? M2R_MEM : M2R_ALUOUT;
            end
            ST_MEM_WR: begin
                MEM_write = 1'b1; IORD_select = IORD_ALUOUT;
            end
            ST_BRANCH: begin
                ALUSRCA_select = SRCA_A; ALU_control = ALU_SUB;
                PC_write = (OPCODE == OP_BEQ) ? zero : !zero;
                PCSOURCE_select = PC_write ? PCSRC_ALUOUT : PCSRC_ALU;
            end
            ST_JUMP: begin
                PC_write = 1'b1; PCSOURCE_select = PCSRC_JUMP;
            end
            ST_EXC_EPC: begin
                ALUSRCB_select = SRCB_FOUR; ALU_control = ALU_SUB; EPC_write = 1'b1;
            end
            ST_EXC_RD, ST_EXC_PC: begin
                MEM_read = 1'b1; IORD_select = IORD_EXC;
                PC_write        = (state == ST_EXC_PC);
                PCSOURCE_select = (state == ST_EXC_PC) ? PCSRC_MEM : PCSRC_ALU;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (EXC_CAUSE)
            EXC_OVF: EXC_ADDR = ADDR_W'(OVF_VEC);
            EXC_OPC: EXC_ADDR = ADDR_W'(OPC_VEC);
            default: EXC_ADDR = '0;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized bench comparing mc_ctrl_fsm to a per-instruction cycle plan
module tb_mc_ctrl_fsm;

`ifdef MC_CTRL_MEM_READY_EN
    localparam int MW = 1;
`else
    localparam int MW = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [5:0] OPCODE, FUNCT;
    logic overflow, zero, mem_ready;
    logic MEM_read, MEM_write, PC_write, IR_write, REG_write, AB_write, ALUOUT_write, EPC_write;
    logic [2:0] ALU_control;
    logic [1:0] ALUSRCA_select, ALUSRCB_select, IORD_select, PCSOURCE_select, EXC_CAUSE;
    logic REGDST_select, MEMTOREG_select;
    logic [31:0] EXC_ADDR;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_WAIT(2), .ADDR_W(32), .OVF_VEC(255), .OPC_VEC(253)) dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .overflow(overflow), .zero(zero),
`ifdef MC_CTRL_MEM_READY_EN
        .MEM_ready(mem_ready),
`endif
        .MEM_read(MEM_read), .MEM_write(MEM_write), .PC_write(PC_write), .IR_write(IR_write),
        .REG_write(REG_write), .AB_write(AB_write), .ALUOUT_write(ALUOUT_write),
        .EPC_write(EPC_write), .ALU_control(ALU_control), .ALUSRCA_select(ALUSRCA_select),
        .ALUSRCB_select(ALUSRCB_select), .IORD_select(IORD_select),
        .PCSOURCE_select(PCSOURCE_select), .REGDST_select(REGDST_select),
        .MEMTOREG_select(MEMTOREG_select), .EXC_CAUSE(EXC_CAUSE), .EXC_ADDR(EXC_ADDR)
    );

    typedef struct packed {
        logic mr, mw, pcw, irw, rw, abw, aow, epcw;
        logic [2:0] alu;
        logic [1:0] sa, sb, iord, pcs;
        logic rd, m2r;
        logic [1:0] cause;
        logic [31:0] eaddr;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    ov;
        bit    zr;
        bit    rst;
        string tag;
    } rec_t;

    rec_t q[$];
    int passed = 0;
    int total  = 0;
    logic [1:0] m_cause = 2'd0;

    function automatic outs_t sample();
        return {MEM_read, MEM_write, PC_write, IR_write, REG_write, AB_write, ALUOUT_write,
                EPC_write, ALU_control, ALUSRCA_select, ALUSRCB_select, IORD_select,
                PCSOURCE_select, REGDST_select, MEMTOREG_select, EXC_CAUSE, EXC_ADDR};
    endfunction

    function automatic outs_t base();
        outs_t o = '0;
        o.cause = m_cause;
        o.eaddr = (m_cause == 2'd1) ? 32'd255 : (m_cause == 2'd2) ? 32'd253 : 32'd0;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input outs_t o, input bit ov, input bit zr, input string tag);
        rec_t r;
        r.o = o; r.ov = ov; r.zr = zr; r.rst = 1'b0; r.tag = tag;
        q.push_back(r);
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic plan_exc();
        outs_t o;
        o = base(); o.sb = 2'd1; o.alu = 3'd2; o.epcw = 1; push(o, rnd(), rnd(), "EXC_EPC");
        for (int i = 0; i < MW; i++) begin
            o = base(); o.mr = 1; o.iord = 2'd2; push(o, rnd(), rnd(), "EXC_RD");
        end
        o = base(); o.mr = 1; o.iord = 2'd2; o.pcw = 1; o.pcs = 2'd3; push(o, rnd(), rnd(), "EXC_PC");
    endtask

    // ov_sel/zr_sel: 0 or 1 forces the deciding flag, 2 draws it at random
    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int ov_sel,
                              input int zr_sel, output int exp_pcw, output bit exc);
        outs_t o;
        bit ov, zr;
        ov = (ov_sel == 2) ? rnd() : bit'(ov_sel);
        zr = (zr_sel == 2) ? rnd() : bit'(zr_sel);
        exc = 0; exp_pcw = 1;
        for (int i = 0; i < MW; i++) begin
            o = base(); o.mr = 1; o.sb = 2'd1; o.alu = 3'd1; push(o, rnd(), rnd(), "FETCH");
        end
        o = base(); o.mr = 1; o.sb = 2'd1; o.alu = 3'd1; o.irw = 1; o.pcw = 1;
        push(o, rnd(), rnd(), "FETCH_WB");
        o = base(); o.abw = 1; o.aow = 1; o.sb = 2'd3; o.alu = 3'd1; push(o, rnd(), rnd(), "DECODE");
        if ((op == 6'h00 && fn inside {6'd32, 6'd34, 6'd36, 6'd42}) || op == 6'h08 || op == 6'h09) begin
            bit r = (op == 6'h00);
            logic [2:0] a;
            bit trap;
            a = !r ? 3'd1 : (fn == 6'd32) ? 3'd1 : (fn == 6'd34) ? 3'd2 : (fn == 6'd36) ? 3'd3 : 3'd7;
            trap = ov && ((r && (fn == 6'd32 || fn == 6'd34)) || op == 6'h08);
            o = base(); o.sa = 2'd1; o.sb = r ? 2'd0 : 2'd2; o.alu = a; o.aow = 1; o.rd = r;
            push(o, rnd(), rnd(), "EXEC");
            o = base(); o.sa = 2'd1; o.sb = r ? 2'd0 : 2'd2; o.alu = a; o.rd = r; o.rw = !trap;
            push(o, ov, rnd(), "ALU_WB");
            if (trap) begin
                m_cause = 2'd1; exc = 1; plan_exc();
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            o = base(); o.sa = 2'd1; o.sb = 2'd2; o.alu = 3'd1; o.aow = 1; push(o, rnd(), rnd(), "MEM_ADDR");
            for (int i = 0; i < MW; i++) begin
                o = base(); o.iord = 2'd1; o.mr = (op == 6'h23); o.mw = (op == 6'h2B);
                push(o, rnd(), rnd(), (op == 6'h23) ? "MEM_RD" : "MEM_WR");
            end
            if (op == 6'h23) begin
                o = base(); o.mr = 1; o.iord = 2'd1; o.rw = 1; o.m2r = 1; push(o, rnd(), rnd(), "MEM_WB");
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            bit taken = (op == 6'h04) ? zr : !zr;
            o = base(); o.sa = 2'd1; o.alu = 3'd2; o.pcw = taken; o.pcs = taken ? 2'd1 : 2'd0;
            push(o, rnd(), zr, "BRANCH");
            exp_pcw = taken ? 2 : 1;
        end else if (op == 6'h02) begin
            o = base(); o.pcw = 1; o.pcs = 2'd2; push(o, rnd(), rnd(), "JUMP");
            exp_pcw = 2;
        end else begin
            m_cause = 2'd2; exc = 1; plan_exc();
        end
    endtask

    task automatic run_plan(output int pcw_seen);
        rec_t r;
        pcw_seen = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            overflow = r.ov; zero = r.zr; reset = r.rst;
            @(negedge clk);
            pcw_seen += int'(PC_write);
            check(r.tag, 64'(sample()), 64'(r.o));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    logic [5:0] op_tab[13] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h23, 6'h2B,
                                6'h04, 6'h05, 6'h02, 6'h3F, 6'h01, 6'h03};
    logic [5:0] fn_tab[6]  = '{6'd32, 6'd34, 6'd36, 6'd42, 6'd0, 6'd7};

    initial begin
        int pcw, exp_pcw;
        bit exc;
        reset = 1'b1; OPCODE = 6'h00; FUNCT = 6'd32; overflow = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(sample()), 64'(0));
        reset = 1'b0;
        push(base(), 1'b0, 1'b0, "IDLE");
        run_plan(pcw);

        // ADD, no overflow: one PC_write (FETCH_WB), FETCH..ALU_WB is MW+4 cycles
        OPCODE = 6'h00; FUNCT = 6'd32;
        plan_instr(OPCODE, FUNCT, 0, 2, exp_pcw, exc);
        check("add_plan_len", 64'(q.size()), 64'(MW + 4));
        run_plan(pcw);
        check("add_pcw", 64'(pcw), 64'(1));

        // ADDI overflow traps to vector 255
        OPCODE = 6'h08; FUNCT = 6'd0;
        plan_instr(OPCODE, FUNCT, 1, 2, exp_pcw, exc);
        run_plan(pcw);
        check("ovf_exc_addr", 64'(EXC_ADDR), 64'd255);
        check("ovf_exc_cause", 64'(EXC_CAUSE), 64'd1);

        // Invalid opcode traps to vector 253
        OPCODE = 6'h3F;
        plan_instr(OPCODE, FUNCT, 2, 2, exp_pcw, exc);
        run_plan(pcw);
        check("opc_exc_addr", 64'(EXC_ADDR), 64'd253);

        OPCODE = 6'h04;
        plan_instr(OPCODE, FUNCT, 2, 0, exp_pcw, exc);
        run_plan(pcw);
        check("beq_not_taken_pcw", 64'(pcw), 64'd1);
        OPCODE = 6'h05;
        plan_instr(OPCODE, FUNCT, 2, 0, exp_pcw, exc);
        run_plan(pcw);
        check("bne_taken_pcw", 64'(pcw), 64'd2);

        // Reset during the first MEM_WR cycle, then IDLE with cause cleared
        OPCODE = 6'h2B;
        plan_instr(OPCODE, FUNCT, 2, 2, exp_pcw, exc);
        for (int i = 0; i < MW - 1; i++) void'(q.pop_back());
        q[q.size() - 1].rst = 1'b1;
        m_cause = 2'd0;
        push(base(), rnd(), rnd(), "IDLE_AFTER_RESET");
        run_plan(pcw);

        for (int n = 0; n < 150; n++) begin
            OPCODE = op_tab[$urandom_range(0, 12)];
            FUNCT  = fn_tab[$urandom_range(0, 5)];
            plan_instr(OPCODE, FUNCT, 2, 2, exp_pcw, exc);
            run_plan(pcw);
            if (!exc) check("rand_pcw_count", 64'(pcw), 64'(exp_pcw));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
